// File: rtl/tic_tac_toe_input.sv
// tic_tac_toe_input
//   Button front end for the tic_tac_toe game. Five raw push-buttons are
//   synchronized, debounced and edge-detected. A press moves a wrapping 3x3
//   cursor, or requests a placement on the cell under the cursor. Placements
//   on an occupied cell, or while the game is over, are refused and reported
//   with a one-cycle `rejected` pulse instead of `place`.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low; clears every register
//   btn_up/down/left/right/select  raw active-high buttons, asynchronous
//   game_over    from tic_tac_toe; refuses all placements while high
//   cell_select  row*3+col of the cursor (combinational)
//   place        one-cycle placement strobe
//   cursor_row   cursor row, 0..2
//   cursor_col   cursor column, 0..2
//   occupied     bit i set once cell i has been placed
//   rejected     one-cycle pulse when a select press is refused
module tic_tac_toe_input #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_select,
  input  logic       game_over,
  output logic [3:0] cell_select,
  output logic       place,
  output logic [1:0] cursor_row,
  output logic [1:0] cursor_col,
  output logic [8:0] occupied,
  output logic       rejected
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit positions inside the packed button vectors.
  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int B_SEL   = 4;

  logic [4:0]       btn_raw;
  logic [4:0]       sync_p0;
  logic [4:0]       sync_p1;
  logic [4:0]       deb_p2;
  logic [4:0]       deb_last_p2;
  logic [CNT_W-1:0] cnt_p2 [5];
  logic [4:0]       press_p3;

  logic [1:0] row_nxt;
  logic [1:0] col_nxt;
  logic [8:0] occ_nxt;
  logic       place_nxt;
  logic       rej_nxt;

  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [1:0] wrap_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'd2 : v - 2'd1;
  endfunction

  assign btn_raw = {btn_select, btn_up, btn_down, btn_left, btn_right};

  // ---- p0/p1: two-flop synchronizer per button ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- p2: debouncer; the level only flips after it has differed for
  // DEBOUNCE_CYCLES consecutive synced cycles ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_p2 <= '0;
      for (int i = 0; i < 5; i++) cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_LAST) begin
          deb_p2[i] <= sync_p1[i];
          cnt_p2[i] <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---- p3: registered press event (rising debounced level only) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_last_p2 <= '0;
      press_p3    <= '0;
    end else begin
      deb_last_p2 <= deb_p2;
      press_p3    <= deb_p2 & ~deb_last_p2;
    end
  end

  // 4-bit row*3+col without a multiplier: row*2 + row + col.
  assign cell_select = {1'b0, cursor_row, 1'b0} + {2'b00, cursor_row} + {2'b00, cursor_col};

  // Priority select > up > down > left > right; lower events in the same
  // cycle are dropped.
  always_comb begin
    row_nxt   = cursor_row;
    col_nxt   = cursor_col;
    occ_nxt   = occupied;
    place_nxt = 1'b0;
    rej_nxt   = 1'b0;
    if (press_p3[B_SEL]) begin
      if (!game_over && !occupied[cell_select]) begin
        place_nxt            = 1'b1;
        occ_nxt[cell_select] = 1'b1;
      end else begin
        rej_nxt = 1'b1;
      end
    end else if (press_p3[B_UP]) begin
      row_nxt = wrap_dec(cursor_row);
    end else if (press_p3[B_DOWN]) begin
      row_nxt = wrap_inc(cursor_row);
    end else if (press_p3[B_LEFT]) begin
      col_nxt = wrap_dec(cursor_col);
    end else if (press_p3[B_RIGHT]) begin
      col_nxt = wrap_inc(cursor_col);
    end
  end

  // ---- p4: action registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cursor_row <= 2'd0;
      cursor_col <= 2'd0;
      occupied   <= '0;
      place      <= 1'b0;
      rejected   <= 1'b0;
    end else begin
      cursor_row <= row_nxt;
      cursor_col <= col_nxt;
      occupied   <= occ_nxt;
      place      <= place_nxt;
      rejected   <= rej_nxt;
    end
  end

endmodule
